// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, one iteration per cycle.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            AbortE,
  output logic            MdStall,
  output logic [XLEN-1:0] MdResultE,
  output logic            MdDone,
  output logic            MdBusy
);

  localparam int unsigned AccW = 2 * XLEN + 1;
  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [2:0]        funct_q, funct_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              sign_q, sign_d;
  logic              rem_sign_q, rem_sign_d;

  // Operand capture decode
  logic              signed_div, sign_a_en, sign_b_en, neg_a, neg_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;

  always_comb begin
    signed_div = FunctE[2] & ~FunctE[0];
    sign_a_en  = (~FunctE[2] & (FunctE[1:0] != 2'b11)) | signed_div;
    sign_b_en  = (FunctE == 3'b001) | signed_div;
    neg_a      = sign_a_en & SrcAE[XLEN-1];
    neg_b      = sign_b_en & SrcBE[XLEN-1];
    mag_a      = neg_a ? -SrcAE : SrcAE;
    mag_b      = neg_b ? -SrcBE : SrcBE;
    div_zero   = FunctE[2] & (SrcBE == '0);
    div_ovf    = signed_div & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
  end

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum;
  logic [AccW-1:0]   mul_next;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_trial;
  logic              div_borrow;
  logic [AccW-1:0]   div_next;

  always_comb begin
    mul_sum    = acc_q[AccW-1:XLEN] + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next   = {mul_sum, acc_q[XLEN-1:0]} >> 1;
    div_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial  = {1'b0, div_sh} - {2'b00, opb_q};
    div_borrow = div_trial[XLEN+1];
    div_next   = {1'b0,
                  div_borrow ? div_sh[XLEN-1:0] : div_trial[XLEN-1:0],
                  acc_q[XLEN-2:0], ~div_borrow};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    funct_d    = funct_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    sign_d     = sign_q;
    rem_sign_d = rem_sign_q;
    if (AbortE) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (StartE) begin
            funct_d    = FunctE;
            opb_d      = mag_b;
            count_d    = '0;
            sign_d     = neg_a ^ neg_b;
            rem_sign_d = neg_a;
            acc_d      = {{(XLEN+1){1'b0}}, mag_a};
            state_d    = StBusy;
            // Special divides bypass iteration with a preloaded, sign-free result
            if (div_zero) begin
              acc_d      = {1'b0, SrcAE, {XLEN{1'b1}}};
              sign_d     = 1'b0;
              rem_sign_d = 1'b0;
              state_d    = StDone;
            end else if (div_ovf) begin
              acc_d      = {{(XLEN+1){1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
              sign_d     = 1'b0;
              rem_sign_d = 1'b0;
              state_d    = StDone;
            end
          end
        end
        StBusy: begin
          acc_d   = funct_q[2] ? div_next : mul_next;
          count_d = count_q + CntW'(1);
          if (count_q == CntW'(XLEN - 1)) begin
            state_d = StDone;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      funct_q    <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      sign_q     <= 1'b0;
      rem_sign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      funct_q    <= funct_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      sign_q     <= sign_d;
      rem_sign_q <= rem_sign_d;
    end
  end

  // Result selection from registered state only
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, sel;

  always_comb begin
    prod     = acc_q[2*XLEN-1:0];
    prod_fix = sign_q ? -prod : prod;
    quot_fix = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = rem_sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (funct_q)
      3'b000:                 sel = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel = quot_fix;
      default:                sel = rem_fix;
    endcase
  end

  always_comb begin
    MdStall   = StartE & (state_q != StDone) & ~rst & ~AbortE;
    MdDone    = (state_q == StDone) & ~rst & ~AbortE;
    MdBusy    = (state_q != StIdle) & ~rst;
    MdResultE = ((state_q == StDone) && !rst) ? sel : '0;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, stall timing, fast paths,
// back-to-back issue, abort and mid-operation reset.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        StartE;
  logic [2:0]  FunctE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        AbortE;
  logic        MdStall;
  logic [31:0] MdResultE;
  logic        MdDone;
  logic        MdBusy;

  int errors;
  int checks;

  muldiv_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .StartE    (StartE),
    .FunctE    (FunctE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .AbortE    (AbortE),
    .MdStall   (MdStall),
    .MdResultE (MdResultE),
    .MdDone    (MdDone),
    .MdBusy    (MdBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline keeps the op in EX while busy; StartE must stay high
  always @(negedge clk) begin
    if (!rst && MdBusy && !StartE) begin
      errors++;
      $display("FAIL start_held: StartE=0 while MdBusy=1 at %0t", $time);
    end
  end

  // Issue one op at posedge+1; return result, stall count and DONE cycle index (-1 on timeout)
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stalls, output int done_cyc);
    StartE   = 1'b1;
    FunctE   = f;
    SrcAE    = a;
    SrcBE    = b;
    stalls   = 0;
    done_cyc = -1;
    res      = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (MdStall) stalls++;
      if (MdDone) begin
        res      = MdResultE;
        done_cyc = c;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    StartE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (MdStall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", MdStall);
    end
    checks++;
    if (MdDone !== 1'b0 || MdBusy !== 1'b0) begin
      errors++; $display("FAIL reset_done_busy got %b%b want 00", MdDone, MdBusy);
    end
    checks++;
    if (MdResultE !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h want 00000000", MdResultE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    checks++;
    if (MdBusy !== 1'b0 || MdDone !== 1'b0 || MdStall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b done=%b stall=%b want 000", MdBusy, MdDone,
               MdStall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int s, d;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, s, d);
    StartE = 1'b0;
    checks++;
    if (r !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mul_result got %h want ffffffeb", r);
    end
    checks++;
    if (s !== 33) begin
      errors++; $display("FAIL mul_stall_cycles got %0d want 33", s);
    end
    checks++;
    if (d !== 33) begin
      errors++; $display("FAIL mul_done_cycle got %0d want 33", d);
    end
  endtask

  task automatic test_ops();
    logic [2:0]  f   [7] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a   [7] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b   [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7};
    logic [31:0] exp [7] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] r;
    int s, d;
    for (int i = 0; i < 7; i++) begin
      run_op(f[i], a[i], b[i], r, s, d);
      StartE = 1'b0;
      checks++;
      if (r !== exp[i] || d !== 33) begin
        errors++;
        $display("FAIL op%0d_f%b got %h@%0d want %h@33", i, f[i], r, d, exp[i]);
      end
    end
  endtask

  task automatic test_fast();
    logic [2:0]  f   [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] a   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    logic [31:0] r;
    int s, d;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], r, s, d);
      StartE = 1'b0;
      checks++;
      if (r !== exp[i] || d !== 1 || s !== 1) begin
        errors++;
        $display("FAIL fast%0d got %h done@%0d stalls=%0d want %h done@1 stalls=1", i, r, d, s,
                 exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int s1, s2, d1, d2;
    run_op(3'b000, 32'd123, 32'hFFFF_FFD3, r1, s1, d1);
    run_op(3'b101, 32'd1000, 32'd7, r2, s2, d2);
    StartE = 1'b0;
    checks++;
    if (r1 !== 32'hFFFF_EA61) begin
      errors++; $display("FAIL b2b_mul got %h want ffffea61", r1);
    end
    checks++;
    if (r2 !== 32'd142) begin
      errors++; $display("FAIL b2b_divu got %h want 0000008e", r2);
    end
    checks++;
    if (s1 + s2 !== 66 || d2 !== 33) begin
      errors++; $display("FAIL b2b_stalls got %0d done2@%0d want 66 done2@33", s1 + s2, d2);
    end
  endtask

  task automatic test_abort();
    int done_seen;
    StartE = 1'b1;
    FunctE = 3'b000;
    SrcAE  = 32'd7;
    SrcBE  = 32'd9;
    repeat (11) @(posedge clk);
    #1;
    AbortE = 1'b1;
    @(negedge clk);
    checks++;
    if (MdStall !== 1'b0 || MdDone !== 1'b0) begin
      errors++; $display("FAIL abort_cycle got stall=%b done=%b want 00", MdStall, MdDone);
    end
    @(posedge clk);
    #1;
    AbortE = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    checks++;
    if (MdBusy !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b want 0", MdBusy);
    end
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (MdDone) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL abort_no_done got %0d done cycles want 0", done_seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid();
    logic [31:0] r;
    int s, d;
    StartE = 1'b1;
    FunctE = 3'b011;
    SrcAE  = 32'hFFFF_FFFF;
    SrcBE  = 32'hFFFF_FFFF;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (MdStall !== 1'b0 || MdDone !== 1'b0 || MdBusy !== 1'b0 || MdResultE !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got stall=%b done=%b busy=%b res=%h want all 0", MdStall,
               MdDone, MdBusy, MdResultE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    checks++;
    if (MdBusy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got busy=%b want 0", MdBusy);
    end
    @(posedge clk);
    #1;
    run_op(3'b000, 32'h0001_2345, 32'h0000_0100, r, s, d);
    StartE = 1'b0;
    checks++;
    if (r !== 32'h0123_4500 || s !== 33) begin
      errors++; $display("FAIL rst_mid_mul got %h stalls=%0d want 01234500 stalls=33", r, s);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    StartE = 1'b0;
    FunctE = 3'b000;
    SrcAE  = '0;
    SrcBE  = '0;
    AbortE = 1'b0;
    test_reset();
    test_mul();
    test_ops();
    test_fast();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
